// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: FSM encodings and field widths.
package pipe_pkg;

    localparam int unsigned STATE_W     = 2;
    localparam int unsigned REG_W       = 5;
    localparam int unsigned STALL_CNT_W = 16;

    localparam logic [STATE_W-1:0] ST_IDLE   = 2'b00;
    localparam logic [STATE_W-1:0] ST_RUN    = 2'b01;
    localparam logic [STATE_W-1:0] ST_STEP   = 2'b10;
    localparam logic [STATE_W-1:0] ST_HALTED = 2'b11;

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard detection: load-use dependency and control-transfer flush request.
module hazard_unit
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             id_branch_taken,
    input  logic             id_jump,
    output logic             load_use,
    output logic             flush_req
);

    // Register 0 is hardwired, so a load into it never creates a dependency.
    always_comb begin
        load_use  = ex_mem_read && (ex_rt != REG_W'(0)) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));
        flush_req = (id_branch_taken || id_jump) && !load_use;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: run/step/halt FSM, hazard gating and performance counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dbg_run,
    input  logic                   dbg_step_mode,
    input  logic                   dbg_step,
    input  logic                   halt_wb,
    input  logic [REG_W-1:0]       id_rs,
    input  logic [REG_W-1:0]       id_rt,
    input  logic                   ex_mem_read,
    input  logic [REG_W-1:0]       ex_rt,
    input  logic                   id_branch_taken,
    input  logic                   id_jump,
    output logic                   clk_en,
    output logic                   stall,
    output logic                   flush,
    output logic                   idex_bubble,
    output logic [STATE_W-1:0]     state,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [STATE_W-1:0] state_nxt;
    logic               step_q;
    logic               step_edge;
    logic               load_use;
    logic               flush_req;

    hazard_unit u_hazard (
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .id_branch_taken (id_branch_taken),
        .id_jump         (id_jump),
        .load_use        (load_use),
        .flush_req       (flush_req)
    );

    // Edge is against the registered level, so a held request yields one step and
    // an edge that happens outside STEP is simply lost rather than queued.
    assign step_edge = dbg_step && !step_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a retiring HALT during an advancing cycle beats everything.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (dbg_run && dbg_step_mode) begin
                    state_nxt = ST_STEP;
                end else if (dbg_run) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_wb && clk_en) begin
                    state_nxt = ST_HALTED;
                end else if (!dbg_run) begin
                    state_nxt = ST_IDLE;
                end else if (dbg_step_mode) begin
                    state_nxt = ST_STEP;
                end
            end
            ST_STEP: begin
                if (halt_wb && clk_en) begin
                    state_nxt = ST_HALTED;
                end else if (!dbg_run) begin
                    state_nxt = ST_IDLE;
                end else if (!dbg_step_mode) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_HALTED;
            end
        endcase
    end

    // Combinational outputs: advance enable and hazard controls gated by it.
    always_comb begin
        clk_en      = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        idex_bubble = 1'b0;
        case (state)
            ST_RUN:  clk_en = 1'b1;
            ST_STEP: clk_en = step_edge;
            default: clk_en = 1'b0;
        endcase
        stall       = clk_en && load_use;
        flush       = clk_en && flush_req;
        idex_bubble = stall;
    end

    // Step-request level register used for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q <= 1'b0;
        end else begin
            step_q <= dbg_step;
        end
    end

    // Saturating performance counters; they only move on advancing cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (clk_en && !(&cycle_cnt)) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (stall && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (default and 4-bit counter instances).
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        dbg_run, dbg_step_mode, dbg_step, halt_wb;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        ex_mem_read, id_branch_taken, id_jump;

    logic        clk_en, stall, flush, idex_bubble;
    logic [1:0]  state;
    logic [31:0] cycle_cnt;
    logic [15:0] stall_cnt;

    logic        clk_en4, stall4, flush4, idex_bubble4;
    logic [1:0]  state4;
    logic [3:0]  cycle_cnt4;
    logic [15:0] stall_cnt4;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_ctrl #(.CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .dbg_run(dbg_run), .dbg_step_mode(dbg_step_mode),
        .dbg_step(dbg_step), .halt_wb(halt_wb), .id_rs(id_rs), .id_rt(id_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_branch_taken(id_branch_taken),
        .id_jump(id_jump), .clk_en(clk_en), .stall(stall), .flush(flush),
        .idex_bubble(idex_bubble), .state(state), .cycle_cnt(cycle_cnt),
        .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .dbg_run(dbg_run), .dbg_step_mode(dbg_step_mode),
        .dbg_step(dbg_step), .halt_wb(halt_wb), .id_rs(id_rs), .id_rt(id_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_branch_taken(id_branch_taken),
        .id_jump(id_jump), .clk_en(clk_en4), .stall(stall4), .flush(flush4),
        .idex_bubble(idex_bubble4), .state(state4), .cycle_cnt(cycle_cnt4),
        .stall_cnt(stall_cnt4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hazards();
        id_rs = '0; id_rt = '0; ex_rt = '0;
        ex_mem_read = 1'b0; id_branch_taken = 1'b0; id_jump = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        dbg_run = 1'b0; dbg_step_mode = 1'b0; dbg_step = 1'b0; halt_wb = 1'b0;
        clear_hazards();

        // Reset state, with a load-use and branch presented: all controls must stay low.
        tick();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_branch_taken = 1'b1;
        #1;
        check("rst_state", 32'(state), 32'h0);
        check("rst_clk_en", 32'(clk_en), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_bubble", 32'(idex_bubble), 32'h0);
        check("rst_cycle_cnt", cycle_cnt, 32'h0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        clear_hazards();
        tick();

        // IDLE -> RUN one cycle after dbg_run.
        reset = 1'b0;
        dbg_run = 1'b1;
        #1;
        check("idle_clk_en", 32'(clk_en), 32'h0);
        check("idle_state", 32'(state), 32'h0);
        tick();
        check("run_state", 32'(state), 32'h1);
        check("run_clk_en", 32'(clk_en), 32'h1);
        check("run_cnt0", cycle_cnt, 32'h0);
        repeat (10) tick();
        check("run_cnt10", cycle_cnt, 32'd10);
        check("run_cnt10_w4", 32'(cycle_cnt4), 32'hA);

        // Load-use on rs outranks a taken branch.
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_branch_taken = 1'b1;
        #1;
        check("lu_stall", 32'(stall), 32'h1);
        check("lu_bubble", 32'(idex_bubble), 32'h1);
        check("lu_flush", 32'(flush), 32'h0);
        tick();
        check("lu_stall_cnt", 32'(stall_cnt), 32'h1);

        // Load into r0 is not a hazard; the branch now flushes.
        ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        check("r0_stall", 32'(stall), 32'h0);
        check("r0_flush", 32'(flush), 32'h1);
        tick();
        check("r0_stall_cnt", 32'(stall_cnt), 32'h1);

        // Load-use on rt with a jump.
        id_branch_taken = 1'b0; id_jump = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3;
        #1;
        check("rt_stall", 32'(stall), 32'h1);
        check("rt_flush", 32'(flush), 32'h0);
        tick();
        check("rt_stall_cnt", 32'(stall_cnt), 32'h2);

        // Load without matching register: jump flushes, no stall.
        id_rt = 5'd8;
        #1;
        check("nm_stall", 32'(stall), 32'h0);
        check("nm_flush", 32'(flush), 32'h1);
        clear_hazards();
        tick();
        check("run_cnt14", cycle_cnt, 32'd14);

        // Saturation of the 4-bit counter after 20 advancing cycles.
        repeat (6) tick();
        check("sat_w4", 32'(cycle_cnt4), 32'hF);
        check("run_cnt20", cycle_cnt, 32'd20);

        // Enter STEP; a 4-cycle step request advances exactly once.
        dbg_step_mode = 1'b1;
        tick();
        check("step_state", 32'(state), 32'h2);
        check("step_idle_en", 32'(clk_en), 32'h0);
        check("step_cnt_in", cycle_cnt, 32'd21);
        dbg_step = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("step_en_%0d", i), 32'(clk_en), (i == 0) ? 32'h1 : 32'h0);
            tick();
        end
        dbg_step = 1'b0;
        check("step_cnt_out", cycle_cnt, 32'd22);

        // Hazard inputs while not advancing produce no controls.
        ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4; id_jump = 1'b1;
        #1;
        check("noadv_stall", 32'(stall), 32'h0);
        check("noadv_flush", 32'(flush), 32'h0);
        clear_hazards();
        tick();

        // Back to RUN, then HALT retires.
        dbg_step_mode = 1'b0;
        tick();
        check("rerun_state", 32'(state), 32'h1);
        check("rerun_cnt", cycle_cnt, 32'd22);
        halt_wb = 1'b1;
        tick();
        halt_wb = 1'b0;
        #1;
        check("halt_state", 32'(state), 32'h3);
        check("halt_clk_en", 32'(clk_en), 32'h0);
        for (int i = 0; i < 4; i++) begin
            dbg_run = (i % 2 == 1);
            tick();
        end
        dbg_run = 1'b1;
        #1;
        check("halt_sticky", 32'(state), 32'h3);
        check("halt_cnt", cycle_cnt, 32'd23);
        check("halt_stall_cnt", 32'(stall_cnt), 32'h2);

        // Reset out of HALTED, run 3 cycles, then async reset mid-cycle.
        reset = 1'b1;
        #1;
        check("halt_rst_state", 32'(state), 32'h0);
        reset = 1'b0;
        tick();
        repeat (3) tick();
        check("rerun3_cnt", cycle_cnt, 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("arst_clk_en", 32'(clk_en), 32'h0);
        check("arst_state", 32'(state), 32'h0);
        check("arst_cnt", cycle_cnt, 32'h0);
        check("arst_stall_cnt", 32'(stall_cnt), 32'h0);

        // Reset mid-step: no extra advance after release with dbg_step still high.
        reset = 1'b0;
        dbg_step_mode = 1'b1;
        tick();
        check("s2_state", 32'(state), 32'h2);
        dbg_step = 1'b1;
        #1;
        check("s2_en", 32'(clk_en), 32'h1);
        reset = 1'b1;
        #1;
        check("s2_rst_en", 32'(clk_en), 32'h0);
        reset = 1'b0;
        tick();
        check("s2_after_state", 32'(state), 32'h2);
        check("s2_after_en", 32'(clk_en), 32'h0);
        tick();
        check("s2_after_cnt", cycle_cnt, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
